seq_rf_arb_2req: RTL
====================

Name: seq_rf_arb_2req

Overview:
- Arbiter/sequencer that shares one 1-read/1-write register file (8 entries x 8 bits) between two requesters.
- Each requester issues read or write requests over a val/rdy handshake.
- The block routes granted requests onto the RF read and write ports and returns a registered response per requester.
- The read port and the write port are arbitrated independently, so one read and one write can issue in the same cycle.

Parameters:
- DATA_W, 8, data width of RF entries and request/response data
- ADDR_W, 3, RF address width (2**ADDR_W entries)

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset_n  in  1  reset, asynchronous assert, active-low
- req_val[i]  in  1  requester i (i=0,1) request valid
- req_rdy[i]  out  1  requester i request accepted this cycle
- req_wr[i]  in  1  1=write, 0=read
- req_addr[i]  in  ADDR_W  RF address
- req_data[i]  in  DATA_W  write data (ignored for reads)
- resp_val[i]  out  1  response valid
- resp_rdy[i]  in  1  response consumed
- resp_data[i]  out  DATA_W  read data; 0 for write acks
- rf_read_addr  out  ADDR_W  to RF read port
- rf_read_data  in  DATA_W  from RF (combinational, same-cycle write-forwarding RF)
- rf_write_en  out  1  to RF write port
- rf_write_addr  out  ADDR_W  to RF write port
- rf_write_data  out  DATA_W  to RF write port

Behaviour:
- Reset (async, reset_n=0):
  - resp_val[0..1]=0, resp_data=0.
  - Read priority pointer rd_prio=0 and write priority pointer wr_prio=0 (requester 0 favoured).
  - Outputs come out of reset immediately, not at the next edge.
- Eligibility: requester i is eligible when req_val[i] && (!resp_val[i] || resp_rdy[i]). This gives one outstanding response per requester, with same-cycle free-and-refill allowed.
- Read arbitration:
  - Candidates are eligible requesters with req_wr=0.
  - One candidate: it wins. Two candidates: requester rd_prio wins.
  - On any read grant to k, rd_prio <= ~k.
- Write arbitration: same as read, using candidates with req_wr=1 and wr_prio. On any write grant to k, wr_prio <= ~k.
- req_rdy[i]: asserted iff i won its port this cycle. It is combinational from req_val/req_wr/resp state; a losing requester holds its request.
- RF drive:
  - rf_read_addr = addr of read winner, else 0.
  - rf_write_en=1 only with a write winner; rf_write_addr and rf_write_data come from that winner, else 0.
- Same-cycle read and write to the same address: the read returns the new write data (via RF forwarding). The block adds no extra logic for this.
- Response timing: latency is exactly 1 cycle.
  - Granted read: at the next edge resp_val[i]<=1 and resp_data[i]<=rf_read_data sampled in the grant cycle.
  - Granted write: resp_val[i]<=1, resp_data[i]<=0.
- Response hold and clear:
  - resp_val/resp_data hold until resp_rdy[i]=1.
  - On consume with no new grant: resp_val[i]<=0 and resp_data is held.
- Write commit: the RF is updated at the edge ending the grant cycle.
  - A later read sees the new value.
  - A read granted earlier is unaffected; its data is already captured.
- Reset mid-operation: pending responses are dropped; RF contents are untouched (the RF is outside this block).
- No combinational path from resp_rdy to resp_val/resp_data. There is a combinational path resp_rdy -> req_rdy.

Test Plan:
- Reset then idle: after reset_n 0->1, resp_val=00, rf_write_en=0, req_rdy=00 with req_val=00.
- Single write/read: req0 wr addr 3 data 0xA5 -> rdy0=1, rf_write_en=1; next cycle resp_val0=1 data 0x00. Then req0 rd addr 3 -> next cycle resp_data0=0xA5.
- Read/write overlap: same cycle, req0 wr addr 5 data 0x3C and req1 rd addr 5 -> both rdy=1; next cycle resp_data1=0x3C (forwarded), resp_val0=1.
- Read contention round-robin: both read continuously, resp_rdy=1, from reset -> grants alternate 0,1,0,1 over 4 cycles; each resp valid 1 cycle after its grant.
- Write contention round-robin: both write addr 0 (0x11 from req0, 0x22 from req1) from reset -> req0 first, req1 next; a following read of addr 0 returns 0x22.
- Backpressure: req0 read gets resp, resp_rdy0=0 for 3 cycles with req_val0=1 -> rdy0=0 and resp_data0 stable during those cycles; req1 is still served. Raising resp_rdy0 gives rdy0=1 the same cycle.
- Async reset mid-op: assert reset_n=0 while resp_val1=1, between clock edges -> resp_val1 drops to 0 immediately.

Source files
------------

// File: rtl/seq_rf_arb_2req.sv
// Two-requester sequencer sharing one 1R/1W register file.
// The read port and the write port each have their own round-robin arbiter.
// Each requester keeps at most one registered response outstanding.

// Two-way round-robin pick: a single candidate always wins, and a tie goes to prio.
module seq_rf_arb_2req_pick (
  input  logic [1:0] cand,
  input  logic       prio,
  output logic [1:0] gnt,
  output logic       prio_d
);
  // Resolve the grant, then point prio at the requester that did not win.
  always_comb begin
    gnt    = 2'b00;
    prio_d = prio;
    case (cand)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = prio ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
    if (gnt != 2'b00) prio_d = gnt[0];
  end
endmodule

// Response register for one requester.
// A grant loads it, a consume clears valid, and otherwise it holds.
module seq_rf_arb_2req_resp #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              gnt,
  input  logic              is_wr,
  input  logic              resp_rdy,
  input  logic [DATA_W-1:0] rd_data,
  output logic              resp_val,
  output logic [DATA_W-1:0] resp_data
);
  logic              resp_val_q, resp_val_d;
  logic [DATA_W-1:0] resp_data_q, resp_data_d;

  // Next response state.
  // A new grant refills the slot in the same cycle the old response is consumed.
  // Write acks return zero data.
  always_comb begin
    resp_val_d  = resp_val_q;
    resp_data_d = resp_data_q;
    if (gnt) begin
      resp_val_d  = 1'b1;
      resp_data_d = is_wr ? '0 : rd_data;
    end else if (resp_rdy) begin
      resp_val_d  = 1'b0;
    end
  end

  // Response register. An asynchronous reset drops any pending response.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      resp_val_q  <= 1'b0;
      resp_data_q <= '0;
    end else begin
      resp_val_q  <= resp_val_d;
      resp_data_q <= resp_data_d;
    end
  end

  assign resp_val  = resp_val_q;
  assign resp_data = resp_data_q;
endmodule

module seq_rf_arb_2req #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [1:0]          req_val,
  output logic [1:0]          req_rdy,
  input  logic [1:0]          req_wr,
  input  logic [2*ADDR_W-1:0] req_addr,
  input  logic [2*DATA_W-1:0] req_data,
  output logic [1:0]          resp_val,
  input  logic [1:0]          resp_rdy,
  output logic [2*DATA_W-1:0] resp_data,
  output logic [ADDR_W-1:0]   rf_read_addr,
  input  logic [DATA_W-1:0]   rf_read_data,
  output logic                rf_write_en,
  output logic [ADDR_W-1:0]   rf_write_addr,
  output logic [DATA_W-1:0]   rf_write_data
);
  logic [1:0][ADDR_W-1:0] addr_a;
  logic [1:0][DATA_W-1:0] data_a;
  logic [1:0][DATA_W-1:0] resp_data_a;
  logic [1:0]             elig, rd_cand, wr_cand, rd_gnt, wr_gnt;
  logic                   rd_prio_q, rd_prio_d, wr_prio_q, wr_prio_d;

  assign addr_a    = req_addr;
  assign data_a    = req_data;
  assign resp_data = resp_data_a;

  // A requester may issue only when its response slot is empty or being drained now.
  // This puts resp_rdy on a combinational path to req_rdy.
  assign elig    = req_val & (~resp_val | resp_rdy);
  assign rd_cand = elig & ~req_wr;
  assign wr_cand = elig & req_wr;

  seq_rf_arb_2req_pick u_rd_pick (
    .cand(rd_cand), .prio(rd_prio_q), .gnt(rd_gnt), .prio_d(rd_prio_d)
  );
  seq_rf_arb_2req_pick u_wr_pick (
    .cand(wr_cand), .prio(wr_prio_q), .gnt(wr_gnt), .prio_d(wr_prio_d)
  );

  // Each requester is either reading or writing, so it wins at most one port.
  assign req_rdy = rd_gnt | wr_gnt;

  // Steer the winners onto the RF ports. Idle ports drive zero.
  always_comb begin
    rf_read_addr  = '0;
    rf_write_en   = 1'b0;
    rf_write_addr = '0;
    rf_write_data = '0;
    if (rd_gnt[1])      rf_read_addr = addr_a[1];
    else if (rd_gnt[0]) rf_read_addr = addr_a[0];
    if (wr_gnt[1]) begin
      rf_write_en   = 1'b1;
      rf_write_addr = addr_a[1];
      rf_write_data = data_a[1];
    end else if (wr_gnt[0]) begin
      rf_write_en   = 1'b1;
      rf_write_addr = addr_a[0];
      rf_write_data = data_a[0];
    end
  end

  // Priority pointers. Requester 0 is favoured out of reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_prio_q <= 1'b0;
      wr_prio_q <= 1'b0;
    end else begin
      rd_prio_q <= rd_prio_d;
      wr_prio_q <= wr_prio_d;
    end
  end

  // One response register per requester.
  // A read captures the RF read data in its grant cycle, so a same-cycle write is forwarded by the RF.
  for (genvar i = 0; i < 2; i++) begin : g_resp
    seq_rf_arb_2req_resp #(.DATA_W(DATA_W)) u_resp (
      .clk      (clk),
      .reset_n  (reset_n),
      .gnt      (req_rdy[i]),
      .is_wr    (req_wr[i]),
      .resp_rdy (resp_rdy[i]),
      .rd_data  (rf_read_data),
      .resp_val (resp_val[i]),
      .resp_data(resp_data_a[i])
    );
  end
endmodule
